// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier control slice.
package mult_pkg;

  // Default multiplier operand width.
  localparam int MULT_WIDTH = 8;

  // Iteration counter width for a given operand width (never below 1 bit).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_control_unit_if.sv
// Operator switches, multiplier LSB and datapath strobes of the multiplier
// sequencer, plus the sequencer's state for observation.
//
// Signalling: there is no valid/ready pair here. Run and ClearA_LoadB are
// synchronous levels sampled on every rising Clk edge; M is the live B[0].
// Every strobe is a one-cycle-per-assertion level that the datapath acts on
// at the rising edge where it is seen high.
interface mult_control_unit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Ld_A;
  logic Ld_B;
  logic Clear_A;
  logic Ld_X;
  logic Clr_X;
  logic Fn;
  logic Shift_En;
  logic Busy;
  logic Done;
  mult_state_t dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  // Operator/datapath side.
  modport master (
    output Run, ClearA_LoadB, M,
    input  Ld_A, Ld_B, Clear_A, Ld_X, Clr_X, Fn, Shift_En, Busy, Done,
    input  dbg_state, dbg_cnt
  );

  // Sequencer side.
  modport slave (
    input  Run, ClearA_LoadB, M,
    output Ld_A, Ld_B, Clear_A, Ld_X, Clr_X, Fn, Shift_En, Busy, Done,
    output dbg_state, dbg_cnt
  );

endinterface

// File: rtl/mult_iter_counter.sv
// Add/shift iteration counter: cleared at the start of an operation, stepped
// once per SHIFT, saturating at WIDTH-1 so it can never wrap.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Terminal count marks the last iteration.
  assign tc = (cnt == CNT_W'(WIDTH - 1));

  // Clear has priority; increment stops at terminal count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_control_unit.sv
// Sequencer for the signed shift-add multiplier: turns the Run and
// ClearA_LoadB switches into load/clear/add/shift strobes, runs exactly WIDTH
// add/shift iterations per Run press and holds the result until Run drops.
module mult_control_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input logic               Clk,
  input logic               Reset,
  mult_control_unit_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  mult_state_t      state;
  mult_state_t      next_state;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_inc;

  // Counter is reloaded in INIT and advanced by each non-final SHIFT.
  assign cnt_clr = (state == INIT);
  assign cnt_inc = (state == SHIFT);

  mult_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign bus.dbg_state = state;
  assign bus.dbg_cnt   = cnt;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a finished operation waits in HOLD for Run to drop so a
  // held Run can never retrigger.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.Run) next_state = INIT;
      INIT:    next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = tc ? HOLD : ADD;
      HOLD:    if (!bus.Run) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; the subtract on the final ADD handles the sign bit of B.
  always_comb begin
    bus.Ld_A     = 1'b0;
    bus.Ld_B     = 1'b0;
    bus.Clear_A  = 1'b0;
    bus.Ld_X     = 1'b0;
    bus.Clr_X    = 1'b0;
    bus.Fn       = 1'b0;
    bus.Shift_En = 1'b0;
    bus.Busy     = 1'b0;
    bus.Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.Run && bus.ClearA_LoadB) begin
          bus.Ld_B    = 1'b1;
          bus.Ld_A    = 1'b1;
          bus.Clear_A = 1'b1;
          bus.Clr_X   = 1'b1;
        end
      end
      INIT: begin
        bus.Ld_A    = 1'b1;
        bus.Clear_A = 1'b1;
        bus.Clr_X   = 1'b1;
        bus.Busy    = 1'b1;
      end
      ADD: begin
        bus.Busy = 1'b1;
        if (bus.M) begin
          bus.Ld_A = 1'b1;
          bus.Ld_X = 1'b1;
          bus.Fn   = tc;
        end
      end
      SHIFT: begin
        bus.Shift_En = 1'b1;
        bus.Busy     = 1'b1;
      end
      HOLD: begin
        bus.Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed bench for mult_control_unit with a small A/B/X datapath model.
module tb_mult_control_unit;
  import mult_pkg::*;

  // Output vector bit order: Ld_A Ld_B Clear_A Ld_X Clr_X Fn Shift_En Busy Done
  localparam logic [8:0] LDA  = 9'h100;
  localparam logic [8:0] LDB  = 9'h080;
  localparam logic [8:0] CLRA = 9'h040;
  localparam logic [8:0] LDX  = 9'h020;
  localparam logic [8:0] CLRX = 9'h010;
  localparam logic [8:0] FN   = 9'h008;
  localparam logic [8:0] SHEN = 9'h004;
  localparam logic [8:0] BUSY = 9'h002;
  localparam logic [8:0] DONE = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  typedef struct {
    logic        run;
    logic        clb;
    logic        m;
    logic [8:0]  exp_out;
    mult_state_t exp_state;
  } vec_t;

  logic Clk;
  logic Reset;
  logic run_i;
  logic clb_i;
  logic m_tied;
  logic use_dp;
  int   checks;
  int   errors;
  int   edge_cnt;

  // Datapath model: A, B, X registers with a 9-bit add/subtract of switch S.
  logic [7:0] a_r  = 8'h00;
  logic [7:0] b_r  = 8'h00;
  logic       x_r  = 1'b0;
  logic [7:0] s_sw = 8'h00;
  logic [7:0] b_sw = 8'h00;
  logic [8:0] sum;

  mult_control_unit_if #(.WIDTH(8)) bus ();

  mult_control_unit #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.Run          = run_i;
  assign bus.ClearA_LoadB = clb_i;
  assign bus.M            = use_dp ? b_r[0] : m_tied;

  // Clock and edge counter.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Datapath register model.
  always_comb sum = bus.Fn ? ({a_r[7], a_r} - {s_sw[7], s_sw})
                           : ({a_r[7], a_r} + {s_sw[7], s_sw});
  always @(posedge Clk) begin
    if (bus.Shift_En) begin
      a_r <= {x_r, a_r[7:1]};
      b_r <= {a_r[0], b_r[7:1]};
    end else begin
      if (bus.Ld_A) a_r <= bus.Clear_A ? 8'h00 : sum[7:0];
      if (bus.Ld_B) b_r <= b_sw;
      if (bus.Clr_X) x_r <= 1'b0;
      else if (bus.Ld_X) x_r <= sum[8];
    end
  end

  function automatic logic [8:0] outs();
    return {bus.Ld_A, bus.Ld_B, bus.Clear_A, bus.Ld_X, bus.Clr_X,
            bus.Fn, bus.Shift_En, bus.Busy, bus.Done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs after the falling edge, then let combinational outputs settle.
  task automatic set_in(input logic run, input logic clb, input logic m);
    @(negedge Clk);
    run_i  = run;
    clb_i  = clb;
    m_tied = m;
    #1;
    chk("mutex_shift_load", 32'(bus.Shift_En && (bus.Ld_A || bus.Ld_B || bus.Ld_X)), 32'd0);
    chk("mutex_ldx_clrx", 32'(bus.Ld_X && bus.Clr_X), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One complete operation with M held at mv; run_mid is Run during the run.
  task automatic do_op(input logic mv, input logic run_mid, input string tag);
    int e0;
    set_in(1'b1, 1'b0, mv);
    e0 = edge_cnt;
    chk({tag, "_idle_out"}, 32'(outs()), 32'(NONE));
    set_in(run_mid, 1'b0, mv);
    chk({tag, "_init_out"}, 32'(outs()), 32'(LDA | CLRA | CLRX | BUSY));
    chk({tag, "_init_st"}, 32'(bus.dbg_state), 32'(INIT));
    for (int k = 0; k < 8; k++) begin
      set_in(run_mid, 1'b0, mv);
      chk({tag, "_add_out"}, 32'(outs()),
          32'(mv ? (LDA | LDX | BUSY | ((k == 7) ? FN : NONE)) : BUSY));
      chk({tag, "_add_cnt"}, 32'(bus.dbg_cnt), 32'(k));
      set_in(run_mid, 1'b0, mv);
      chk({tag, "_shift_out"}, 32'(outs()), 32'(SHEN | BUSY));
    end
    set_in(run_mid, 1'b0, mv);
    chk({tag, "_hold_out"}, 32'(outs()), 32'(DONE));
    chk({tag, "_latency"}, 32'(edge_cnt - e0), 32'd18);
  endtask

  task automatic do_mult(input logic [7:0] bv, input logic [7:0] sv,
                         input logic [15:0] exp_p, input string tag);
    bit done;
    b_sw = bv;
    s_sw = sv;
    set_in(1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      set_in(1'b1, 1'b0, 1'b0);
      if (bus.Done) done = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    set_in(1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    chk({tag, "_product"}, 32'({a_r, b_r}), 32'(exp_p));
  endtask

  vec_t vecs[10];

  initial begin
    int e0;
    int shifts;
    bit found;
    bit done;
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    run_i    = 1'b0;
    clb_i    = 1'b0;
    m_tied   = 1'b0;
    use_dp   = 1'b0;
    Reset    = 1'b1;

    // Reset state.
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_out", 32'(outs()), 32'(NONE));
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("reset_cnt", 32'(bus.dbg_cnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // IDLE decode, ClearA_LoadB for 3 cycles, Run priority, first ADD/SHIFT.
    vecs[0] = '{1'b0, 1'b0, 1'b0, NONE, IDLE};
    vecs[1] = '{1'b0, 1'b1, 1'b0, LDB | LDA | CLRA | CLRX, IDLE};
    vecs[2] = '{1'b0, 1'b1, 1'b0, LDB | LDA | CLRA | CLRX, IDLE};
    vecs[3] = '{1'b0, 1'b1, 1'b0, LDB | LDA | CLRA | CLRX, IDLE};
    vecs[4] = '{1'b0, 1'b0, 1'b0, NONE, IDLE};
    vecs[5] = '{1'b1, 1'b1, 1'b0, NONE, IDLE};
    vecs[6] = '{1'b1, 1'b1, 1'b0, LDA | CLRA | CLRX | BUSY, INIT};
    vecs[7] = '{1'b0, 1'b1, 1'b1, LDA | LDX | BUSY, ADD};
    vecs[8] = '{1'b0, 1'b1, 1'b0, SHEN | BUSY, SHIFT};
    vecs[9] = '{1'b0, 1'b1, 1'b0, BUSY, ADD};
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].run, vecs[i].clb, vecs[i].m);
      chk($sformatf("vec%0d_out", i), 32'(outs()), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_st", i), 32'(bus.dbg_state), 32'(vecs[i].exp_state));
    end

    // M tied 1, Run dropped mid-operation: sequence completes, then IDLE.
    do_reset();
    do_op(1'b1, 1'b0, "m1");
    set_in(1'b0, 1'b0, 1'b1);
    chk("m1_back_idle", 32'(bus.dbg_state), 32'(IDLE));

    // M tied 0, Run held 40 cycles: one operation, Done held until Run drops.
    do_op(1'b0, 1'b1, "m0");
    for (int i = 0; i < 21; i++) begin
      set_in(1'b1, 1'b1, 1'b0);
      chk("hold_done", 32'(outs()), 32'(DONE));
    end
    set_in(1'b0, 1'b0, 1'b0);
    chk("hold_release_out", 32'(outs()), 32'(DONE));
    set_in(1'b0, 1'b0, 1'b0);
    chk("hold_to_idle", 32'(bus.dbg_state), 32'(IDLE));
    chk("idle_after_hold_out", 32'(outs()), 32'(NONE));

    // Asynchronous reset during SHIFT at cnt=3, then a full fresh operation.
    set_in(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      set_in(1'b1, 1'b0, 1'b1);
      if (bus.dbg_state == SHIFT && bus.dbg_cnt == 3'd3) found = 1'b1;
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_out", 32'(outs()), 32'(NONE));
    chk("rst_mid_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_mid_cnt", 32'(bus.dbg_cnt), 32'd0);
    @(negedge Clk);
    run_i = 1'b0;
    Reset = 1'b0;
    set_in(1'b1, 1'b0, 1'b1);
    e0 = edge_cnt;
    shifts = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      set_in(1'b0, 1'b0, 1'b1);
      if (bus.Shift_En) shifts++;
      if (bus.Done) done = 1'b1;
    end
    chk("rst_rerun_done", 32'(done), 32'd1);
    chk("rst_rerun_shifts", 32'(shifts), 32'd8);
    chk("rst_rerun_latency", 32'(edge_cnt - e0), 32'd18);
    set_in(1'b0, 1'b0, 1'b0);

    // Integrated with the register model.
    use_dp = 1'b1;
    do_mult(8'h07, 8'hFD, 16'hFFEB, "mul_7_m3");
    do_mult(8'h80, 8'h80, 16'h4000, "mul_m128_m128");
    use_dp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
